keypoint_collector: RTL and testbench



---
 rtl/kp_pkg.sv | 30 +++
 rtl/keypoint_collector_if.sv | 30 +++
 rtl/kp_fifo.sv | 61 ++++++
 rtl/keypoint_collector.sv | 142 ++++++++++++++
 tb/tb_keypoint_collector.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kp_pkg.sv
// kp_pkg
// Purpose: shared widths, the packed FIFO entry layout and the collector FSM
// state encoding used by the keypoint collector slice.
// Contents:
//   COORD_W / ORI_W / SCORE_W - field widths of one keypoint
//   KP_ENTRY_W                - width of one packed FIFO entry (38 bits)
//   kp_state_e                - IDLE / COLLECT / DRAIN / DONE
//   kp_entry_t                - {x, y, orientation, score}, x in the top bits
package kp_pkg;

  localparam int COORD_W    = 10;
  localparam int ORI_W      = 10;
  localparam int SCORE_W    = 8;
  localparam int KP_ENTRY_W = 2 * COORD_W + ORI_W + SCORE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ORI_W-1:0]   orientation;
    logic [SCORE_W-1:0] score;
  } kp_entry_t;

endpackage

// File: rtl/keypoint_collector_if.sv
// keypoint_collector_if
// Purpose: ready/valid output stream carrying the FIFO head keypoint.
// Signals:
//   o_valid        - head entry present (driven by the collector)
//   i_ready        - consumer accepts the head entry (driven by the consumer)
//   o_x, o_y       - head keypoint position
//   o_orientation  - head keypoint angle
//   o_score        - head keypoint corner score
// Modports: master = collector side, slave = consumer side.
interface keypoint_collector_if;
  import kp_pkg::*;

  logic               o_valid;
  logic               i_ready;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic [ORI_W-1:0]   o_orientation;
  logic [SCORE_W-1:0] o_score;

  modport master (
    output o_valid, o_x, o_y, o_orientation, o_score,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_x, o_y, o_orientation, o_score,
    output i_ready
  );

endinterface

// File: rtl/kp_fifo.sv
// kp_fifo
// Purpose: first-word-fall-through FIFO for packed keypoint entries.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   i_push       - write i_data (honoured when not full, or when popping too)
//   i_pop        - drop the head entry (honoured when not empty)
//   i_data       - entry to write
//   o_data       - head entry, forced to zero while empty
//   o_empty      - no entries stored
//   o_full       - DEPTH entries stored
module kp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 38
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign o_empty = (wrPtr_q == rdPtr_q);
  assign o_full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A push into a full FIFO is still legal when the head leaves on the same
  // edge: the write lands in the slot being vacated.
  assign doPush = i_push && (!o_full || i_pop);
  assign doPop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer has moved.
  always_ff @(posedge i_clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= i_data;
  end

  // Zeroing the head while empty keeps the output fields clean in reset.
  assign o_data = o_empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/keypoint_collector.sv
// keypoint_collector
// Purpose: gathers keypoints from the FAST detector for one frame into a
// FWFT FIFO, counts accepted keypoints, flags drops, and pulses when the
// frame has fully drained to the consumer.
// Ports:
//   i_clk, i_rst             - clock, asynchronous active-high reset
//   i_start, i_end, i_flag   - frame start / frame end / keypoint strobe
//   i_coordinate_X/Y         - keypoint position
//   i_orientation, i_score   - keypoint angle and corner score
//   kpOut                    - ready/valid stream of the FIFO head
//   o_kp_count               - keypoints accepted in the current/last frame
//   o_overflow, o_capped     - per-frame sticky drop flags (FIFO full / cap)
//   o_sync_err               - i_start seen outside IDLE, cleared by reset
//   o_frame_done             - one-cycle pulse after the frame has drained
module keypoint_collector
  import kp_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int MAX_KP = 512
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_end,
  input  logic               i_flag,
  input  logic [COORD_W-1:0] i_coordinate_X,
  input  logic [COORD_W-1:0] i_coordinate_Y,
  input  logic [ORI_W-1:0]   i_orientation,
  input  logic [SCORE_W-1:0] i_score,
  keypoint_collector_if.master kpOut,
  output logic [9:0]         o_kp_count,
  output logic               o_overflow,
  output logic               o_capped,
  output logic               o_sync_err,
  output logic               o_frame_done
);

  localparam logic [9:0] MaxKp = 10'(MAX_KP);

  kp_state_e  state_q;
  logic [9:0] kpCount_q;
  logic       overflow_q;
  logic       capped_q;
  logic       syncErr_q;
  logic       frameDone_q;

  kp_entry_t  pushEntry;
  kp_entry_t  headEntry;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       startIdle;
  logic       candidate;
  logic       pop;
  logic       room;
  logic       capHit;
  logic       accept;
  logic       capReject;
  logic       ovfReject;
  logic [9:0] effCount;

  assign pushEntry = '{x: i_coordinate_X, y: i_coordinate_Y,
                       orientation: i_orientation, score: i_score};

  kp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KP_ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_pop   (pop),
    .i_data  (pushEntry),
    .o_data  (headEntry),
    .o_empty (fifoEmpty),
    .o_full  (fifoFull)
  );

  // Push/drop decision. The start cycle already belongs to the new frame, so
  // its strobe is a candidate and the cap is judged against a zero count.
  always_comb begin
    startIdle = (state_q == IDLE) && i_start;
    candidate = i_flag && (startIdle || (state_q == COLLECT));
    pop       = !fifoEmpty && kpOut.i_ready;
    room      = !fifoFull || pop;
    effCount  = startIdle ? 10'd0 : kpCount_q;
    capHit    = (effCount >= MaxKp);
    accept    = candidate && room && !capHit;
    capReject = candidate && capHit;
    ovfReject = candidate && !capHit && !room;
  end

  // Frame FSM with its counter and flags. A new frame restarts the count and
  // the per-frame flags on the same edge that enters COLLECT, while a drop in
  // that very cycle still registers against the new frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      kpCount_q   <= '0;
      overflow_q  <= 1'b0;
      capped_q    <= 1'b0;
      syncErr_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      kpCount_q   <= effCount + 10'(accept);
      overflow_q  <= (overflow_q && !startIdle) || ovfReject;
      capped_q    <= (capped_q && !startIdle) || capReject;
      if (i_start && (state_q != IDLE)) syncErr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (i_start) state_q <= COLLECT;
        end
        COLLECT: begin
          if (i_end) state_q <= DRAIN;
        end
        DRAIN: begin
          if (fifoEmpty) begin
            state_q     <= DONE;
            frameDone_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kpOut.o_valid       = !fifoEmpty;
  assign kpOut.o_x           = headEntry.x;
  assign kpOut.o_y           = headEntry.y;
  assign kpOut.o_orientation = headEntry.orientation;
  assign kpOut.o_score       = headEntry.score;

  assign o_kp_count   = kpCount_q;
  assign o_overflow   = overflow_q;
  assign o_capped     = capped_q;
  assign o_sync_err   = syncErr_q;
  assign o_frame_done = frameDone_q;

endmodule

// File: tb/tb_keypoint_collector.sv
// tb_keypoint_collector
// Purpose: directed bench for keypoint_collector. A main instance (MAX_KP=512)
// and a capped instance (MAX_KP=4) see the same detector stimulus; monitors
// record every popped entry and every frame-done pulse on the falling edge.
module tb_keypoint_collector;
  import kp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       endIn = 1'b0;
  logic       flag = 1'b0;
  logic [9:0] xIn = '0;
  logic [9:0] yIn = '0;
  logic [9:0] oriIn = '0;
  logic [7:0] scoreIn = '0;

  logic [9:0] kpCount, kpCountCap;
  logic       overflow, overflowCap;
  logic       capped, cappedCap;
  logic       syncErr, syncErrCap;
  logic       frameDone, frameDoneCap;

  int vectors = 0;
  int miscompares = 0;
  int doneCnt = 0;
  int doneCntCap = 0;
  int capPops = 0;
  logic [37:0] outQ [$];

  keypoint_collector_if kpIf ();
  keypoint_collector_if kpIfCap ();

  keypoint_collector #(.DEPTH(16), .MAX_KP(512)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(endIn), .i_flag(flag),
    .i_coordinate_X(xIn), .i_coordinate_Y(yIn), .i_orientation(oriIn),
    .i_score(scoreIn), .kpOut(kpIf), .o_kp_count(kpCount),
    .o_overflow(overflow), .o_capped(capped), .o_sync_err(syncErr),
    .o_frame_done(frameDone)
  );

  keypoint_collector #(.DEPTH(16), .MAX_KP(4)) dutCap (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(endIn), .i_flag(flag),
    .i_coordinate_X(xIn), .i_coordinate_Y(yIn), .i_orientation(oriIn),
    .i_score(scoreIn), .kpOut(kpIfCap), .o_kp_count(kpCountCap),
    .o_overflow(overflowCap), .o_capped(cappedCap), .o_sync_err(syncErrCap),
    .o_frame_done(frameDoneCap)
  );

  always #5 clk = ~clk;

  // Falling-edge monitors: a pop happens at the next rising edge whenever
  // valid and ready are both high here.
  always @(negedge clk) begin
    if (kpIf.o_valid && kpIf.i_ready)
      outQ.push_back({kpIf.o_x, kpIf.o_y, kpIf.o_orientation, kpIf.o_score});
    if (kpIfCap.o_valid && kpIfCap.i_ready) capPops++;
    if (frameDone) doneCnt++;
    if (frameDoneCap) doneCntCap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReady(input logic r);
    kpIf.i_ready    = r;
    kpIfCap.i_ready = r;
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic f,
                               input logic [9:0] x, input logic [9:0] y);
    start   = s;
    endIn   = e;
    flag    = f;
    xIn     = x;
    yIn     = y;
    oriIn   = x ^ 10'h155;
    scoreIn = y[7:0] + 8'd3;
    tick();
    start = 1'b0;
    endIn = 1'b0;
    flag  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a frame-done pulse, then checks exactly one arrived.
  task automatic waitFrameDone(input string tag, input bit useCap);
    int base;
    int n;
    base = useCap ? doneCntCap : doneCnt;
    n = 0;
    while (((useCap ? doneCntCap : doneCnt) == base) && (n < 300)) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checkOutput(tag, 32'((useCap ? doneCntCap : doneCnt) - base), 32'd1);
  endtask

  initial begin
    setReady(1'b0);
    repeat (2) tick();

    // Reset state
    checkOutput("rst_valid", 32'(kpIf.o_valid), 32'd0);
    checkOutput("rst_count", 32'(kpCount), 32'd0);
    checkOutput("rst_flags", {28'd0, overflow, capped, syncErr, frameDone}, 32'd0);
    checkOutput("rst_fields", {2'd0, kpIf.o_x, kpIf.o_y, kpIf.o_orientation[1:0]}, 32'd0);
    checkOutput("rst_score", 32'(kpIf.o_score), 32'd0);
    rst = 1'b0;
    tick();

    // Sparse frame with the consumer always ready
    setReady(1'b1);
    outQ.delete();
    applyStimulus(1, 0, 0, 10'd0, 10'd0);
    applyStimulus(0, 0, 1, 10'd5, 10'd7);
    applyStimulus(0, 0, 1, 10'd100, 10'd3);
    applyStimulus(0, 0, 1, 10'd639, 10'd639);
    applyStimulus(0, 1, 0, 10'd0, 10'd0);
    waitFrameDone("sparse_done_once", 0);
    checkOutput("sparse_n", 32'(outQ.size()), 32'd3);
    if (outQ.size() == 3) begin
      checkOutput("sparse_e0", 32'(outQ[0][37:18]), {12'd0, 10'd5, 10'd7});
      checkOutput("sparse_e1", 32'(outQ[1][37:18]), {12'd0, 10'd100, 10'd3});
      checkOutput("sparse_e2", 32'(outQ[2][37:18]), {12'd0, 10'd639, 10'd639});
      checkOutput("sparse_e2_ori", 32'(outQ[2][17:8]), 32'(10'd639 ^ 10'h155));
      checkOutput("sparse_e0_score", 32'(outQ[0][7:0]), 32'd10);
    end
    checkOutput("sparse_count", 32'(kpCount), 32'd3);

    // Overflow: consumer stalled, 20 flags into 16 slots
    setReady(1'b0);
    outQ.delete();
    applyStimulus(1, 0, 0, 10'd0, 10'd0);
    applyStimulus(0, 0, 1, 10'd0, 10'd1);
    checkOutput("ovf_latency_valid", 32'(kpIf.o_valid), 32'd1);
    checkOutput("ovf_latency_x", 32'(kpIf.o_x), 32'd0);
    checkOutput("ovf_latency_y", 32'(kpIf.o_y), 32'd1);
    for (int i = 1; i < 20; i++) applyStimulus(0, 0, 1, 10'(i), 10'(i + 1));
    applyStimulus(0, 1, 0, 10'd0, 10'd0);
    checkOutput("ovf_count", 32'(kpCount), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_capped", 32'(capped), 32'd0);
    checkOutput("ovf_head_stable", 32'(kpIf.o_x), 32'd0);
    setReady(1'b1);
    waitFrameDone("ovf_done_once", 0);
    checkOutput("ovf_n", 32'(outQ.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < outQ.size())
        checkOutput($sformatf("ovf_e%0d", i), 32'(outQ[i][37:18]),
                    {12'd0, 10'(i), 10'(i + 1)});
    repeat (3) tick();

    // Full FIFO plus a flag while popping: push accepted, no overflow
    setReady(1'b0);
    outQ.delete();
    applyStimulus(1, 0, 0, 10'd0, 10'd0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 10'(100 + i), 10'd9);
    setReady(1'b1);
    applyStimulus(0, 0, 1, 10'd200, 10'd9);
    setReady(1'b0);
    checkOutput("fullpop_overflow", 32'(overflow), 32'd0);
    checkOutput("fullpop_count", 32'(kpCount), 32'd17);
    applyStimulus(0, 0, 1, 10'd201, 10'd9);
    checkOutput("fullpop_still_full", 32'(overflow), 32'd1);
    applyStimulus(0, 1, 0, 10'd0, 10'd0);
    setReady(1'b1);
    waitFrameDone("fullpop_done_once", 0);
    checkOutput("fullpop_n", 32'(outQ.size()), 32'd17);
    if (outQ.size() == 17) begin
      checkOutput("fullpop_first", 32'(outQ[0][37:28]), 32'd100);
      checkOutput("fullpop_16th", 32'(outQ[15][37:28]), 32'd115);
      checkOutput("fullpop_last", 32'(outQ[16][37:28]), 32'd200);
    end
    repeat (3) tick();

    // Cap: MAX_KP=4 instance, 6 flags with consumer ready
    capPops = 0;
    applyStimulus(1, 0, 0, 10'd0, 10'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 10'(300 + i), 10'd1);
    applyStimulus(0, 1, 0, 10'd0, 10'd0);
    waitFrameDone("cap_done_once", 1);
    checkOutput("cap_pops", 32'(capPops), 32'd4);
    checkOutput("cap_capped", 32'(cappedCap), 32'd1);
    checkOutput("cap_overflow", 32'(overflowCap), 32'd0);
    checkOutput("cap_count", 32'(kpCountCap), 32'd4);
    checkOutput("cap_main_uncapped", 32'(capped), 32'd0);
    repeat (3) tick();

    // Boundary: flag in IDLE dropped, start-cycle flag and flag+end kept
    outQ.delete();
    applyStimulus(0, 0, 1, 10'd77, 10'd77);
    applyStimulus(1, 0, 1, 10'd9, 10'd8);
    applyStimulus(0, 1, 1, 10'd88, 10'd66);
    waitFrameDone("bound_done_once", 0);
    checkOutput("bound_n", 32'(outQ.size()), 32'd2);
    if (outQ.size() == 2) begin
      checkOutput("bound_start_flag", 32'(outQ[0][37:28]), 32'd9);
      checkOutput("bound_end_flag", 32'(outQ[1][37:28]), 32'd88);
    end
    checkOutput("bound_count", 32'(kpCount), 32'd2);
    checkOutput("bound_no_sync", 32'(syncErr), 32'd0);
    repeat (3) tick();

    // Sync error mid-frame, then reset during DRAIN
    setReady(1'b0);
    applyStimulus(1, 0, 0, 10'd0, 10'd0);
    applyStimulus(0, 0, 1, 10'd1, 10'd1);
    applyStimulus(1, 0, 1, 10'd2, 10'd2);
    checkOutput("sync_err", 32'(syncErr), 32'd1);
    checkOutput("sync_continues", 32'(kpCount), 32'd2);
    checkOutput("sync_state", 32'(dut.state_q), 32'(COLLECT));
    applyStimulus(0, 1, 0, 10'd0, 10'd0);
    checkOutput("drain_state", 32'(dut.state_q), 32'(DRAIN));
    checkOutput("drain_valid", 32'(kpIf.o_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(kpIf.o_valid), 32'd0);
    checkOutput("midrst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("midrst_sync", 32'(syncErr), 32'd0);
    checkOutput("midrst_fields", 32'(kpIf.o_x), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 1, 10'd5, 10'd5);
    checkOutput("postrst_needs_start", 32'(kpIf.o_valid), 32'd0);
    checkOutput("postrst_state", 32'(dut.state_q), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
